// File: rtl/multicycle_controller.sv
// Multicycle sequencer for the Redux-V core.
// Walks one instruction at a time through FETCH/DECODE/EXEC/MEM/WB and drives the per-cycle
// strobes (IR latch, PC update, register-file write, memory requests) for the datapath.
// Every output is decoded combinationally from the registered state, plus the memory acks,
// opcode and zero flag where a state needs them.
// Optional feature: define MC_PERF_EN to build the cycle and retired-instruction counters;
// without it cycle_cnt and instr_cnt are tied to zero and no counter logic exists.
module multicycle_controller #(
    // Cycles a memory request may wait unacknowledged before ERR; 0 disables the timeout
    parameter int unsigned WAIT_MAX = 15,
    // Width of the performance counters
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             retire,
    output logic [2:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    // Encodings are visible on the debug port, so they are pinned explicitly
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StErr    = 3'd7
    } state_e;

    // PC source selects
    localparam logic [1:0] PcSelInc    = 2'b00;
    localparam logic [1:0] PcSelBranch = 2'b01;
    localparam logic [1:0] PcSelJump   = 2'b10;

    // Opcode classes that EXEC cares about; everything from 0100 up is ALU/immediate
    localparam logic [3:0] OpBranch = 4'b0000;
    localparam logic [3:0] OpJump   = 4'b0001;
    localparam logic [3:0] OpLoad   = 4'b0010;
    localparam logic [3:0] OpStore  = 4'b0011;

    // Wait counter only has to reach WAIT_MAX; keep at least one bit when the timeout is off
    localparam int unsigned       WaitW     = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [WaitW-1:0]  WaitMax   = WaitW'(WAIT_MAX);
    localparam bit                TimeoutEn = (WAIT_MAX != 0);

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_q, wait_d;

    logic               is_store;
    logic               req_active;
    logic               req_ack;
    logic               timeout;

    // Store vs load is decided from the opcode still held in the IR during MEM
    assign is_store = (opcode == OpStore);

    // A memory request is outstanding in FETCH (instruction side) and MEM (data side)
    always_comb begin
        req_active = 1'b0;
        req_ack    = 1'b0;
        unique case (state_q)
            StFetch: begin
                req_active = 1'b1;
                req_ack    = imem_ack;
            end
            StMem: begin
                req_active = 1'b1;
                req_ack    = dmem_ack;
            end
            default: begin
                req_active = 1'b0;
                req_ack    = 1'b0;
            end
        endcase
    end

    // Timeout fires only when the budget is exhausted and the ack is still missing;
    // an ack in that very cycle wins
    assign timeout = TimeoutEn && req_active && !req_ack && (wait_q == WaitMax);

    // Wait counter: counts unacked request cycles, zero everywhere else so that entry into
    // FETCH/MEM always starts from a clean count
    always_comb begin
        wait_d = '0;
        if (req_active && !req_ack && !timeout && TimeoutEn) begin
            wait_d = wait_q + WaitW'(1);
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PcSelInc;
        retire   = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end

            StFetch: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
                if (imem_ack) begin
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d = StErr;
                end
            end

            StDecode: begin
                state_d = StExec;
            end

            StExec: begin
                case (opcode)
                    OpBranch: begin
                        pc_we   = 1'b1;
                        pc_sel  = zero ? PcSelBranch : PcSelInc;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    OpJump: begin
                        pc_we   = 1'b1;
                        pc_sel  = PcSelJump;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                    OpLoad, OpStore: begin
                        // Address is formed this cycle; memory access follows
                        state_d = StMem;
                    end
                    default: begin
                        rf_we   = 1'b1;
                        pc_we   = 1'b1;
                        pc_sel  = PcSelInc;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end

            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack) begin
                    if (is_store) begin
                        // Store completes in its ack cycle; no write-back needed
                        pc_we   = 1'b1;
                        pc_sel  = PcSelInc;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (timeout) begin
                    state_d = StErr;
                end
            end

            StWb: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = PcSelInc;
                retire  = 1'b1;
                state_d = StFetch;
            end

            StErr: begin
                // Parked until reset; all strobes stay at their defaults
                state_d = StErr;
            end

            default: begin
                // Unused encoding: treat as a fault rather than silently resuming
                state_d = StErr;
            end
        endcase
    end

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Debug and error outputs follow the registered state directly
    assign state = state_q;
    assign err   = (state_q == StErr);

`ifdef MC_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    // Counters advance every cycle / every retire, and freeze once the core has faulted
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (state_q != StErr) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            if (retire) begin
                instr_cnt_d = instr_cnt_q + CNT_W'(1);
            end
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
// Inputs change on the falling clock edge and outputs are sampled 1 ns later, so every check
// sees the state registered by the preceding rising edge. WAIT_MAX is set to 4.
module tb_multicycle_controller;

    localparam int unsigned CNT_W = 32;

    logic             clk;
    logic             rst_n;
    logic [3:0]       opcode;
    logic             zero;
    logic             imem_ack;
    logic             dmem_ack;
    logic             imem_req;
    logic             ir_we;
    logic             dmem_req;
    logic             dmem_we;
    logic             rf_we;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             retire;
    logic [2:0]       state;
    logic             err;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    int checks;
    int failures;

    // Strobe vector: imem_req ir_we dmem_req dmem_we rf_we pc_we pc_sel[1:0] retire err
    logic [9:0] strb;
    assign strb = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, retire, err};

    localparam logic [9:0] SNone    = 10'b00_0000_0000;
    localparam logic [9:0] SFetch   = 10'b10_0000_0000;
    localparam logic [9:0] SFetchAk = 10'b11_0000_0000;
    localparam logic [9:0] SAlu     = 10'b00_0011_0010;
    localparam logic [9:0] SBrTaken = 10'b00_0001_0110;
    localparam logic [9:0] SBrNot   = 10'b00_0001_0010;
    localparam logic [9:0] SJump    = 10'b00_0001_1010;
    localparam logic [9:0] SLoadMem = 10'b00_1000_0000;
    localparam logic [9:0] SStAck   = 10'b00_1101_0010;
    localparam logic [9:0] SErr     = 10'b00_0000_0001;

    multicycle_controller #(
        .WAIT_MAX (4),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .zero      (zero),
        .imem_ack  (imem_ack),
        .dmem_ack  (dmem_ack),
        .imem_req  (imem_req),
        .ir_we     (ir_we),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .rf_we     (rf_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .retire    (retire),
        .state     (state),
        .err       (err),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck run still ends
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check state and strobes for the current cycle, then advance to the next falling edge
    task automatic cyc(input string tag, input logic [2:0] es, input logic [9:0] eb);
        #1;
        chk({tag, "_state"}, 32'(state), 32'(es));
        chk({tag, "_strobes"}, 32'(strb), 32'(eb));
        @(negedge clk);
    endtask

    // FETCH with a 1-cycle ack, then DECODE presenting the given opcode
    task automatic fetch_decode(input string tag, input logic [3:0] op);
        imem_ack = 1'b1;
        cyc({tag, "_fetch"}, 3'd1, SFetchAk);
        imem_ack = 1'b0;
        opcode   = op;
        cyc({tag, "_decode"}, 3'd2, SNone);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        opcode   = 4'b0000;
        zero     = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_strobes", 32'(strb), 32'(SNone));
        chk("rst_cycle_cnt", cycle_cnt, 32'd0);
        chk("rst_instr_cnt", instr_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU op: IDLE -> FETCH -> DECODE -> EXEC -> FETCH
        cyc("alu_idle", 3'd0, SNone);
        fetch_decode("alu", 4'b1000);
        cyc("alu_exec", 3'd3, SAlu);

        // Branch taken / not taken, then jump
        fetch_decode("br1", 4'b0000);
        zero = 1'b1;
        cyc("br1_exec", 3'd3, SBrTaken);
        zero = 1'b0;
        fetch_decode("br0", 4'b0000);
        cyc("br0_exec", 3'd3, SBrNot);
        fetch_decode("jmp", 4'b0001);
        cyc("jmp_exec", 3'd3, SJump);

        // Load with three wait cycles, ack on the fourth request cycle
        fetch_decode("ld", 4'b0010);
        cyc("ld_exec", 3'd3, SNone);
        for (int i = 0; i < 3; i++) begin
            cyc("ld_mem_wait", 3'd4, SLoadMem);
        end
        dmem_ack = 1'b1;
        cyc("ld_mem_ack", 3'd4, SLoadMem);
        dmem_ack = 1'b0;
        cyc("ld_wb", 3'd5, SAlu);

        // Store with a stray imem_ack during DECODE that must not latch the IR
        imem_ack = 1'b1;
        cyc("st_fetch", 3'd1, SFetchAk);
        opcode = 4'b0011;
        cyc("st_decode_stray_ack", 3'd2, SNone);
        imem_ack = 1'b0;
        cyc("st_exec", 3'd3, SNone);
        dmem_ack = 1'b1;
        cyc("st_mem_ack", 3'd4, SStAck);
        dmem_ack = 1'b0;

        // Timeout: five unacked FETCH cycles (first one here) then sticky ERR
        cyc("to_fetch1", 3'd1, SFetch);
        for (int i = 0; i < 4; i++) begin
            cyc("to_fetch_wait", 3'd1, SFetch);
        end
        cyc("to_err", 3'd7, SErr);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        cyc("to_err_sticky1", 3'd7, SErr);
        cyc("to_err_sticky2", 3'd7, SErr);

        // Async reset clears ERR immediately
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        chk("err_rst_state", 32'(state), 32'd0);
        chk("err_rst_strobes", 32'(strb), 32'(SNone));
        @(negedge clk);
        rst_n = 1'b1;

        // Ack arriving in the fifth request cycle beats the timeout
        cyc("ack5_idle", 3'd0, SNone);
        for (int i = 0; i < 4; i++) begin
            cyc("ack5_fetch_wait", 3'd1, SFetch);
        end
        imem_ack = 1'b1;
        cyc("ack5_fetch_ack", 3'd1, SFetchAk);
        imem_ack = 1'b0;
        opcode   = 4'b0010;
        cyc("ack5_decode", 3'd2, SNone);

        // Reset pulse during MEM of a load aborts it
        cyc("abort_exec", 3'd3, SNone);
        #1;
        chk("abort_mem_state", 32'(state), 32'd4);
        chk("abort_mem_strobes", 32'(strb), 32'(SLoadMem));
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_rst_state", 32'(state), 32'd0);
        chk("abort_rst_strobes", 32'(strb), 32'(SNone));
        dmem_ack = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_hold_state", 32'(state), 32'd0);
        chk("abort_hold_strobes", 32'(strb), 32'(SNone));
        @(negedge clk);
        dmem_ack = 1'b0;
        rst_n    = 1'b1;
        cyc("abort_idle", 3'd0, SNone);
        cyc("abort_refetch", 3'd1, SFetch);

        // Ten back-to-back ALU instructions from a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc("perf_idle", 3'd0, SNone);
        for (int i = 0; i < 10; i++) begin
            fetch_decode("perf", 4'(4 + i));
            cyc("perf_exec", 3'd3, SAlu);
        end
        #1;
        chk("perf_state", 32'(state), 32'd1);
`ifdef MC_PERF_EN
        chk("perf_instr_cnt", instr_cnt, 32'd10);
        chk("perf_cycle_cnt", cycle_cnt, 32'd31);
`else
        chk("perf_instr_cnt_tied", instr_cnt, 32'd0);
        chk("perf_cycle_cnt_tied", cycle_cnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
